// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0180;
  localparam int unsigned ALIGN_BITS           = 2;

endpackage

// File: rtl/pc_sequencer.sv
// Program counter for the MIPS fetch stage: boot delay, fetch handshake,
// redirect/exception loading, halt/resume, PC confined to a low address window.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned N            = 32,
  parameter int unsigned ADDR_BITS    = 20,
  parameter logic [N-1:0] RESET_VECTOR = N'(DEFAULT_RESET_VECTOR),
  parameter logic [N-1:0] EXC_VECTOR   = N'(DEFAULT_EXC_VECTOR),
  parameter int unsigned BOOT_CYCLES  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_Stall,
  input  logic         i_Redirect_Valid,
  input  logic [N-1:0] i_Redirect_Target,
  input  logic         i_Exception,
  input  logic         i_Halt,
  input  logic         i_Resume,
  input  logic         i_Fetch_Ready,
  output logic         o_Fetch_Valid,
  output logic [N-1:0] o_PCValue_dw,
  output logic [N-1:0] o_PCPlus4_dw,
  output logic         o_Misaligned,
  output logic [N-1:0] o_BadAddr_dw
);

  localparam logic [N-1:0] MASK   = N'((64'(1) << ADDR_BITS) - 64'(1));
  localparam logic [N-1:0] EXC_M  = EXC_VECTOR & MASK;
  localparam logic [N-1:0] RST_M  = RESET_VECTOR & MASK;
  localparam int unsigned  CW     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);

  pc_state_t     state, state_next;
  logic [CW-1:0] boot_cnt, boot_cnt_next;
  logic [N-1:0]  pc, pc_next;
  logic [N-1:0]  bad_addr, bad_addr_next;
  logic          misaligned_next;
  logic          active;
  logic          target_misaligned;

  assign active            = (state != BOOT);
  assign target_misaligned = |i_Redirect_Target[ALIGN_BITS-1:0];
  assign o_Fetch_Valid     = (state == RUN) && !i_Stall;
  assign o_PCPlus4_dw      = (pc + N'(4)) & MASK;
  assign o_PCValue_dw      = pc;
  assign o_BadAddr_dw      = bad_addr;

  // Halt/resume transitions are resolved first; exception and misaligned
  // redirect then force RUN on top of them.
  always_comb begin
    pc_next         = pc;
    state_next      = state;
    boot_cnt_next   = boot_cnt;
    bad_addr_next   = bad_addr;
    misaligned_next = 1'b0;

    case (state)
      BOOT: begin
        if (boot_cnt == BOOT_LAST) state_next = RUN;
        else boot_cnt_next = boot_cnt + CW'(1);
      end
      RUN: begin
        if (i_Halt && !i_Exception && !i_Redirect_Valid) state_next = HALT;
      end
      HALT: begin
        if (i_Resume) state_next = RUN;
      end
      default: state_next = BOOT;
    endcase

    if (active && i_Exception) begin
      pc_next    = EXC_M;
      state_next = RUN;
    end else if (active && i_Redirect_Valid) begin
      if (target_misaligned) begin
        pc_next         = EXC_M;
        misaligned_next = 1'b1;
        bad_addr_next   = i_Redirect_Target & MASK;
        state_next      = RUN;
      end else begin
        pc_next = i_Redirect_Target & MASK;
      end
    end else if (o_Fetch_Valid && i_Fetch_Ready) begin
      pc_next = o_PCPlus4_dw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= BOOT;
      boot_cnt     <= '0;
      pc           <= RST_M;
      bad_addr     <= '0;
      o_Misaligned <= 1'b0;
    end else begin
      state        <= state_next;
      boot_cnt     <= boot_cnt_next;
      pc           <= pc_next;
      bad_addr     <= bad_addr_next;
      o_Misaligned <= misaligned_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_Stall, i_Redirect_Valid, i_Exception, i_Halt, i_Resume, i_Fetch_Ready;
  logic [31:0] i_Redirect_Target;
  logic        o_Fetch_Valid, o_Misaligned;
  logic [31:0] o_PCValue_dw, o_PCPlus4_dw, o_BadAddr_dw;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .N(32), .ADDR_BITS(20), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h180), .BOOT_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .i_Stall(i_Stall),
    .i_Redirect_Valid(i_Redirect_Valid), .i_Redirect_Target(i_Redirect_Target),
    .i_Exception(i_Exception), .i_Halt(i_Halt), .i_Resume(i_Resume),
    .i_Fetch_Ready(i_Fetch_Ready), .o_Fetch_Valid(o_Fetch_Valid),
    .o_PCValue_dw(o_PCValue_dw), .o_PCPlus4_dw(o_PCPlus4_dw),
    .o_Misaligned(o_Misaligned), .o_BadAddr_dw(o_BadAddr_dw)
  );

  typedef struct {
    logic        stall, rv, exc, halt, res, rdy;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_val, e_mis;
    logic [31:0] e_bad;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t mk(input logic stall, rv, exc, halt, res, rdy,
                              input logic [31:0] tgt, e_pc,
                              input logic e_val, e_mis, input logic [31:0] e_bad);
    vec_t v;
    v.stall = stall; v.rv = rv; v.exc = exc; v.halt = halt; v.res = res; v.rdy = rdy;
    v.tgt = tgt; v.e_pc = e_pc; v.e_val = e_val; v.e_mis = e_mis; v.e_bad = e_bad;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic stall, rv, exc, halt, res, rdy, input logic [31:0] tgt);
    i_Stall = stall; i_Redirect_Valid = rv; i_Exception = exc;
    i_Halt = halt; i_Resume = res; i_Fetch_Ready = rdy; i_Redirect_Target = tgt;
  endtask

  initial begin
    //            stall rv exc halt res rdy tgt            pc          val mis bad
    vecs[0]  = mk(0, 0, 0, 0, 0, 1, 32'h0,         32'h0,       0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 1, 32'h0,         32'h0,       1, 0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 1, 32'h0,         32'h4,       1, 0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 1, 32'h0,         32'h8,       1, 0, 32'h0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 1, 32'h0,         32'hC,       1, 0, 32'h0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 32'h0,         32'h10,      1, 0, 32'h0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h10,      1, 0, 32'h0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h10,      1, 0, 32'h0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h10,      1, 0, 32'h0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 1, 32'h0,         32'h14,      1, 0, 32'h0);
    vecs[10] = mk(1, 0, 0, 0, 0, 1, 32'h0,         32'h14,      0, 0, 32'h0);
    vecs[11] = mk(1, 1, 1, 0, 0, 1, 32'h200,       32'h180,     0, 0, 32'h0);
    vecs[12] = mk(0, 0, 0, 0, 0, 1, 32'h0,         32'h184,     1, 0, 32'h0);
    vecs[13] = mk(0, 1, 0, 0, 0, 1, 32'h203,       32'h180,     1, 1, 32'h203);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h180,     1, 0, 32'h203);
    vecs[15] = mk(0, 1, 0, 0, 0, 0, 32'hFFFFC,     32'hFFFFC,   1, 0, 32'h203);
    vecs[16] = mk(0, 0, 0, 0, 0, 1, 32'h0,         32'h0,       1, 0, 32'h203);
    vecs[17] = mk(0, 1, 0, 0, 0, 0, 32'hFFF12340,  32'h12340,   1, 0, 32'h203);
    vecs[18] = mk(0, 1, 0, 0, 0, 0, 32'h201,       32'h180,     1, 1, 32'h201);
    vecs[19] = mk(0, 1, 0, 0, 0, 0, 32'hABC302,    32'h180,     1, 1, 32'hBC302);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h180,     1, 0, 32'hBC302);
    vecs[21] = mk(0, 0, 0, 1, 0, 0, 32'h0,         32'h180,     0, 0, 32'hBC302);
    vecs[22] = mk(0, 0, 0, 0, 0, 1, 32'h0,         32'h180,     0, 0, 32'hBC302);
    vecs[23] = mk(0, 1, 0, 0, 0, 0, 32'h400,       32'h400,     0, 0, 32'hBC302);
    vecs[24] = mk(0, 0, 0, 0, 1, 0, 32'h0,         32'h400,     1, 0, 32'hBC302);
    vecs[25] = mk(0, 0, 0, 0, 0, 1, 32'h0,         32'h404,     1, 0, 32'hBC302);
    vecs[26] = mk(0, 0, 0, 1, 0, 1, 32'h0,         32'h408,     0, 0, 32'hBC302);
    vecs[27] = mk(0, 0, 0, 1, 1, 0, 32'h0,         32'h408,     1, 0, 32'hBC302);
    vecs[28] = mk(0, 0, 0, 1, 0, 0, 32'h0,         32'h408,     0, 0, 32'hBC302);
    vecs[29] = mk(0, 0, 1, 0, 0, 0, 32'h0,         32'h180,     1, 0, 32'hBC302);
    vecs[30] = mk(0, 0, 0, 1, 0, 0, 32'h0,         32'h180,     0, 0, 32'hBC302);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 32'h0);
    #2;
    check("reset_pc", o_PCValue_dw, 32'h0);
    check("reset_valid", 32'(o_Fetch_Valid), 32'h0);
    check("reset_mis", 32'(o_Misaligned), 32'h0);
    check("reset_bad", o_BadAddr_dw, 32'h0);
    check("reset_pcplus4", o_PCPlus4_dw, 32'h4);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 31; i++) begin
      drive(vecs[i].stall, vecs[i].rv, vecs[i].exc, vecs[i].halt, vecs[i].res,
            vecs[i].rdy, vecs[i].tgt);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pc", i), o_PCValue_dw, vecs[i].e_pc);
      check($sformatf("v%0d_valid", i), 32'(o_Fetch_Valid), 32'(vecs[i].e_val));
      check($sformatf("v%0d_mis", i), 32'(o_Misaligned), 32'(vecs[i].e_mis));
      check($sformatf("v%0d_bad", i), o_BadAddr_dw, vecs[i].e_bad);
      if (i == 15) check("wrap_pcplus4", o_PCPlus4_dw, 32'h0);
      @(negedge clk);
    end

    // Asynchronous reset while halted, away from any clock edge.
    #2;
    reset = 1'b1;
    drive(0, 1, 1, 0, 0, 1, 32'h500);
    #1;
    check("async_rst_pc", o_PCValue_dw, 32'h0);
    check("async_rst_valid", 32'(o_Fetch_Valid), 32'h0);
    check("async_rst_bad", o_BadAddr_dw, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Exception and redirect held through BOOT must be ignored.
    @(posedge clk); #1;
    check("boot1_pc", o_PCValue_dw, 32'h0);
    check("boot1_valid", 32'(o_Fetch_Valid), 32'h0);
    @(posedge clk); #1;
    check("boot2_pc", o_PCValue_dw, 32'h0);
    check("boot2_valid", 32'(o_Fetch_Valid), 32'h1);
    check("boot2_mis", 32'(o_Misaligned), 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 32'h0);
    @(posedge clk); #1;
    check("post_boot_pc", o_PCValue_dw, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
